map_rom_arbiter: RTL and testbench

MAP_ROM_ARBITER -- requirements
Module: map_rom_arbiter

---
 rtl/map_rom_arbiter.sv | 117 +++++++++++
 tb/tb_map_rom_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/map_rom_arbiter.sv
// Two-stage arbiter sharing one map ROM between a held tracer request and a per-cycle overlay request.
// Optional starvation guard for the tracer is enabled by defining MAP_ARB_STARVE_GUARD_EN.
module map_rom_arbiter #(
    parameter int MAP_WBITS    = 4,
    parameter int MAP_HBITS    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tr_req_i,
    input  logic [MAP_WBITS-1:0] tr_col_i,
    input  logic [MAP_HBITS-1:0] tr_row_i,
    output logic                 tr_ack_o,
    output logic                 tr_val_o,
    input  logic                 ov_req_i,
    input  logic [MAP_WBITS-1:0] ov_col_i,
    input  logic [MAP_HBITS-1:0] ov_row_i,
    output logic                 ov_valid_o,
    output logic                 ov_val_o,
    output logic [MAP_WBITS-1:0] rom_col_o,
    output logic [MAP_HBITS-1:0] rom_row_o,
    input  logic                 rom_val_i
);

    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_TR = 2'd1, TAG_OV = 2'd2} tag_e;

    tag_e                 tag_q, tag_d;
    logic [MAP_WBITS-1:0] rom_col_q, rom_col_d;
    logic [MAP_HBITS-1:0] rom_row_q, rom_row_d;
    logic                 tr_wait_q, tr_wait_d;
    logic                 tr_ack_q, tr_ack_d, tr_val_q, tr_val_d;
    logic                 ov_valid_q, ov_valid_d, ov_val_q, ov_val_d;
    logic                 tr_elig, tr_win, starve_hit;

    // A granted tracer request must be seen low before it can be granted again,
    // and a grant still in S1 or in its ack cycle blocks a new one.
    assign tr_elig = tr_req_i && !tr_wait_q && (tag_q != TAG_TR) && !tr_ack_q;
    assign tr_win  = tr_elig && (!ov_req_i || starve_hit);

`ifdef MAP_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == STARVE_MAX);

    always_comb begin
        starve_d = starve_q;
        if (tr_win || !tr_req_i)
            starve_d = '0;
        else if (tr_elig && ov_req_i && (starve_q != STARVE_MAX))
            starve_d = starve_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        tag_d     = TAG_NONE;
        rom_col_d = rom_col_q;
        rom_row_d = rom_row_q;
        tr_wait_d = tr_wait_q;
        if (tr_win) begin
            tag_d     = TAG_TR;
            rom_col_d = tr_col_i;
            rom_row_d = tr_row_i;
        end else if (ov_req_i) begin
            tag_d     = TAG_OV;
            rom_col_d = ov_col_i;
            rom_row_d = ov_row_i;
        end
        if (tr_win)        tr_wait_d = 1'b1;
        else if (!tr_req_i) tr_wait_d = 1'b0;

        // S2: the owner of last cycle's address captures the ROM data
        tr_ack_d   = (tag_q == TAG_TR);
        ov_valid_d = (tag_q == TAG_OV);
        tr_val_d   = (tag_q == TAG_TR) ? rom_val_i : tr_val_q;
        ov_val_d   = (tag_q == TAG_OV) ? rom_val_i : ov_val_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q      <= TAG_NONE;
            rom_col_q  <= '0;
            rom_row_q  <= '0;
            tr_wait_q  <= 1'b0;
            tr_ack_q   <= 1'b0;
            tr_val_q   <= 1'b0;
            ov_valid_q <= 1'b0;
            ov_val_q   <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            rom_col_q  <= rom_col_d;
            rom_row_q  <= rom_row_d;
            tr_wait_q  <= tr_wait_d;
            tr_ack_q   <= tr_ack_d;
            tr_val_q   <= tr_val_d;
            ov_valid_q <= ov_valid_d;
            ov_val_q   <= ov_val_d;
        end
    end

    assign tr_ack_o   = tr_ack_q;
    assign tr_val_o   = tr_val_q;
    assign ov_valid_o = ov_valid_q;
    assign ov_val_o   = ov_val_q;
    assign rom_col_o  = rom_col_q;
    assign rom_row_o  = rom_row_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Randomized and directed bench for map_rom_arbiter against a cycle-stamped grant model.
module tb_map_rom_arbiter;

    localparam int W = 4;
    localparam int H = 4;
    localparam int LIMIT = 8;
`ifdef MAP_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         tr_req, ov_req;
    logic [W-1:0] tr_col, ov_col;
    logic [H-1:0] tr_row, ov_row;
    logic         tr_ack_o, tr_val_o, ov_valid_o, ov_val_o, rom_val;
    logic [W-1:0] rom_col_o;
    logic [H-1:0] rom_row_o;
    logic         rom_mem [0:255];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign rom_val = rom_mem[{rom_row_o, rom_col_o}];

    map_rom_arbiter #(.MAP_WBITS(W), .MAP_HBITS(H), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .tr_req_i(tr_req), .tr_col_i(tr_col), .tr_row_i(tr_row),
        .tr_ack_o(tr_ack_o), .tr_val_o(tr_val_o),
        .ov_req_i(ov_req), .ov_col_i(ov_col), .ov_row_i(ov_row),
        .ov_valid_o(ov_valid_o), .ov_val_o(ov_val_o),
        .rom_col_o(rom_col_o), .rom_row_o(rom_row_o), .rom_val_i(rom_val)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the ROM each cycle, from the arbitration rules.
    // owner: 0 none, 1 tracer, 2 overlay. Outputs appear one edge after the grant.
    int       cyc = 0;
    int       last_tr = -100;
    bit       waiting = 1'b0;
    int       starve = 0;
    int       p_who = 0;
    int       p_addr = 0;
    bit       e_tr_ack, e_tr_val, e_ov_valid, e_ov_val;
    int       e_col, e_row;

    always @(posedge clk) begin
        if (reset) begin
            e_tr_ack = 0; e_tr_val = 0; e_ov_valid = 0; e_ov_val = 0;
            e_col = 0; e_row = 0; p_who = 0; waiting = 0; starve = 0; last_tr = -100;
        end else begin
            bit elig, force_tr;
            int who;
            e_tr_ack   = (p_who == 1);
            e_ov_valid = (p_who == 2);
            if (p_who == 1) e_tr_val = rom_mem[p_addr];
            if (p_who == 2) e_ov_val = rom_mem[p_addr];
            elig     = tr_req && !waiting && (cyc - last_tr >= 3);
            force_tr = GUARD && elig && (starve == LIMIT);
            who = (ov_req && !force_tr) ? 2 : (elig ? 1 : 0);
            if (who == 1 || !tr_req) starve = 0;
            else if (elig && who == 2 && starve < LIMIT) starve++;
            if (who == 1) begin
                waiting = 1; last_tr = cyc;
                e_col = tr_col; e_row = tr_row;
            end else begin
                if (!tr_req) waiting = 0;
                if (who == 2) begin e_col = ov_col; e_row = ov_row; end
            end
            p_addr = e_row * 16 + e_col;
            p_who  = who;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tr_ack", tr_ack_o, e_tr_ack);
            chk("tr_val", tr_val_o, e_tr_val);
            chk("ov_valid", ov_valid_o, e_ov_valid);
            chk("ov_val", ov_val_o, e_ov_val);
            chk("rom_col", rom_col_o, e_col);
            chk("rom_row", rom_row_o, e_row);
        end
    end

    // Tracer agent: drops tr_req hold_cfg cycles after seeing its ack.
    int hold_cfg = 0;
    int drop_cnt = -1;
    bit just_dropped = 0;

    task automatic step();
        @(negedge clk);
        just_dropped = 0;
        if (tr_req && tr_ack_o) drop_cnt = hold_cfg;
        if (drop_cnt == 0) begin
            tr_req = 0; drop_cnt = -1; just_dropped = 1;
        end else if (drop_cnt > 0) drop_cnt--;
    endtask

    initial begin
        logic [7:0] sv_valid, sv_val;
        int n_ack, n_ovlow, ack_at;

        reset = 1; tr_req = 0; ov_req = 0;
        tr_col = '0; tr_row = '0; ov_col = '0; ov_row = '0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 1'($urandom);
        rom_mem[8'h53] = 1'b1;
        rom_mem[8'h00] = 1'b1; rom_mem[8'h01] = 1'b0;
        rom_mem[8'h02] = 1'b0; rom_mem[8'h03] = 1'b1;

        step(); step();
        chk_en = 1;
        chk("reset_outs", {tr_ack_o, tr_val_o, ov_valid_o, ov_val_o, rom_col_o, rom_row_o}, 0);
        reset = 0;
        step();

        // Tracer alone at (3,5); held for a while after its ack.
        hold_cfg = 4;
        tr_req = 1; tr_col = 3; tr_row = 5;
        step();
        chk("tr_addr", {rom_col_o, rom_row_o}, {4'd3, 4'd5});
        chk("tr_ack_early", tr_ack_o, 0);
        step();
        chk("tr_ack_val", {tr_ack_o, tr_val_o}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tr_no_reack", tr_ack_o, 0);
        end
        hold_cfg = 0;
        for (int i = 0; i < 4; i++) step();

        // Overlay burst over row 0, pattern 1,0,0,1.
        for (int i = 0; i < 6; i++) begin
            ov_req = (i < 4); ov_col = W'(i); ov_row = 0;
            step();
            sv_valid[i] = ov_valid_o; sv_val[i] = ov_val_o;
        end
        chk("ov_valid_seq", sv_valid[5:0], 6'b011110);
        chk("ov_val_seq", {sv_val[1], sv_val[2], sv_val[3], sv_val[4]}, 4'b1001);
        step(); step();

        // Contention: overlay held for 20 cycles against a waiting tracer.
        n_ack = 0; n_ovlow = 0; ack_at = -1;
        tr_req = 1; tr_col = 4'd9; tr_row = 4'd2;
        for (int i = 0; i < 22; i++) begin
            ov_req = (i < 20); ov_col = W'($urandom); ov_row = H'($urandom);
            step();
            if (tr_ack_o) begin n_ack++; ack_at = i; end
            if (i >= 1 && i <= 20 && !ov_valid_o) n_ovlow++;
        end
        chk("contend_acks", n_ack, 1);
        if (GUARD) begin
            chk("guard_ack_cycle", ack_at, 9);
            chk("guard_ov_drops", n_ovlow, 1);
        end else begin
            chk("noguard_ack_cycle", ack_at, 21);
            chk("noguard_ov_drops", n_ovlow, 0);
        end
        for (int i = 0; i < 3; i++) step();

        // Reset one cycle after a tracer grant, tracer held through reset.
        tr_req = 1; tr_col = 4'd1; tr_row = 4'd7;
        step();
        reset = 1;
        step();
        chk("rst_outs", {tr_ack_o, tr_val_o, ov_valid_o, ov_val_o, rom_col_o, rom_row_o}, 0);
        step();
        reset = 0;
        step();
        chk("rst_no_stale_ack", tr_ack_o, 0);
        step();
        chk("rst_reacq_ack", tr_ack_o, 1);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            ov_req = (k % 500 < 250) ? (($urandom % 8) != 0) : (($urandom % 2) != 0);
            ov_col = W'($urandom); ov_row = H'($urandom);
            if (!tr_req && !just_dropped && ($urandom % 4) == 0) begin
                tr_req = 1; tr_col = W'($urandom); tr_row = H'($urandom);
                hold_cfg = $urandom % 3;
            end
            reset = (($urandom % 300) == 0);
            step();
        end
        reset = 0; ov_req = 0; tr_req = 0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
